// File: rtl/dmem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter_pkg
// Description : Shared types and defaults for the DMEM port arbiter.
//               Supplies the owner encoding and the default widths/limits.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_arbiter_pkg;

    localparam int c_DEFAULT_REG_WIDTH    = 32;
    localparam int c_DEFAULT_DMEM_DEPTH   = 256;
    localparam int c_DEFAULT_STARVE_LIMIT = 4;

    // Which requester owns the access currently on the DMEM port
    typedef enum logic [1:0] {
        OWNER_NONE = 2'b00,
        OWNER_CPU  = 2'b01,
        OWNER_DMA  = 2'b10
    } owner_t;

    // Bits needed to count from 0 up to and including the starvation limit
    function automatic int starve_cnt_width(input int limit);
        return $clog2(limit + 1);
    endfunction

endpackage : dmem_arbiter_pkg
`default_nettype wire

// File: rtl/dmem_arb_starve_cnt.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arb_starve_cnt
// Description : Saturating count of consecutive cycles in which a pending DMA
//               request was refused. When the count reaches STARVE_LIMIT the
//               next slot is forced to DMA.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_arb_starve_cnt
    import dmem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = c_DEFAULT_STARVE_LIMIT
) (
    input  logic clk,
    input  logic reset,
    input  logic i_dma_req,
    input  logic i_dma_gnt,
    output logic o_force_dma
);

    localparam int                 c_CNT_W = starve_cnt_width(STARVE_LIMIT);
    localparam logic [c_CNT_W-1:0] c_LIMIT = c_CNT_W'(STARVE_LIMIT);
    localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

    // Reject limits outside the supported 1..255 range at elaboration
    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : g_bad_limit
        $error("dmem_arb_starve_cnt: STARVE_LIMIT must be in 1..255");
    end

    logic [c_CNT_W-1:0] r_cnt_q;
    logic [c_CNT_W-1:0] w_cnt_d;

    // Count refused DMA cycles; a grant or a dropped request restarts the wait
    always_comb begin
        w_cnt_d = r_cnt_q;
        if (!i_dma_req || i_dma_gnt) begin
            w_cnt_d = '0;
        end else if (r_cnt_q != c_LIMIT) begin
            w_cnt_d = r_cnt_q + c_ONE;
        end
    end

    // Counter register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt_q <= '0;
        end else begin
            r_cnt_q <= w_cnt_d;
        end
    end

    assign o_force_dma = (r_cnt_q == c_LIMIT);

endmodule : dmem_arb_starve_cnt
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter
// Description : Shares the single DMEM port between the MEM-stage CPU port
//               and a loader/debug DMA port. CPU has fixed priority; a
//               starvation guard forces one DMA slot after STARVE_LIMIT
//               refused cycles. The winning command is registered onto the
//               DMEM port and read data returns to its requester one cycle
//               after the grant with a valid strobe.
//               Optional macro DMEM_ARB_ADDR_CHECK_EN adds a sticky addr_err
//               output, suppresses out-of-range writes and zeroes
//               out-of-range read data.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int REG_WIDTH    = c_DEFAULT_REG_WIDTH,
    parameter int DMEM_DEPTH   = c_DEFAULT_DMEM_DEPTH,
    parameter int STARVE_LIMIT = c_DEFAULT_STARVE_LIMIT
) (
    input  logic                 clk,
    input  logic                 reset,
    // CPU (MEM stage) port
    input  logic                 cpu_req,
    input  logic                 cpu_wr_en,
    input  logic [REG_WIDTH-1:0] cpu_addr,
    input  logic [REG_WIDTH-1:0] cpu_wr_data,
    output logic                 cpu_stall,
    output logic                 cpu_rd_valid,
    output logic [REG_WIDTH-1:0] cpu_rd_data,
    // DMA port
    input  logic                 dma_req,
    input  logic                 dma_wr_en,
    input  logic [REG_WIDTH-1:0] dma_addr,
    input  logic [REG_WIDTH-1:0] dma_wr_data,
    output logic                 dma_gnt,
    output logic                 dma_rd_valid,
    output logic [REG_WIDTH-1:0] dma_rd_data,
    // DMEM port
    output logic                 dmem_wr_en,
    output logic [REG_WIDTH-1:0] dmem_addr,
    output logic [REG_WIDTH-1:0] dmem_wr_data,
`ifdef DMEM_ARB_ADDR_CHECK_EN
    output logic                 addr_err,
`endif
    input  logic [REG_WIDTH-1:0] dmem_rd_data
);

    // A zero-word memory is meaningless; catch it at elaboration
    if (DMEM_DEPTH < 1) begin : g_bad_depth
        $error("dmem_arbiter: DMEM_DEPTH must be at least 1");
    end

    logic                 w_force_dma;
    logic                 w_cpu_gnt;
    logic                 w_win;
    logic                 w_win_wr_en;
    logic [REG_WIDTH-1:0] w_win_addr;
    logic [REG_WIDTH-1:0] w_win_wr_data;
    logic                 w_addr_oor;
    logic [REG_WIDTH-1:0] w_rd_return;

    owner_t               w_owner_d,        r_owner_q;
    logic                 w_rd_pending_d,   r_rd_pending_q;
    logic                 w_dmem_wr_en_d,   r_dmem_wr_en_q;
    logic [REG_WIDTH-1:0] w_dmem_addr_d,    r_dmem_addr_q;
    logic [REG_WIDTH-1:0] w_dmem_wr_data_d, r_dmem_wr_data_q;

    dmem_arb_starve_cnt #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve_cnt (
        .clk         (clk),
        .reset       (reset),
        .i_dma_req   (dma_req),
        .i_dma_gnt   (dma_gnt),
        .o_force_dma (w_force_dma)
    );

    // Grants: CPU first unless DMA has waited long enough to be forced in
    always_comb begin
        w_cpu_gnt = cpu_req & ~w_force_dma;
        dma_gnt   = dma_req & (~cpu_req | w_force_dma);
        cpu_stall = cpu_req & ~w_cpu_gnt;
    end

    // Select the winner's command; with no grant the address/data hold
    always_comb begin
        w_owner_d     = OWNER_NONE;
        w_win_wr_en   = 1'b0;
        w_win_addr    = r_dmem_addr_q;
        w_win_wr_data = r_dmem_wr_data_q;
        if (w_cpu_gnt) begin
            w_owner_d     = OWNER_CPU;
            w_win_wr_en   = cpu_wr_en;
            w_win_addr    = cpu_addr;
            w_win_wr_data = cpu_wr_data;
        end else if (dma_gnt) begin
            w_owner_d     = OWNER_DMA;
            w_win_wr_en   = dma_wr_en;
            w_win_addr    = dma_addr;
            w_win_wr_data = dma_wr_data;
        end
    end

    assign w_win = (w_owner_d != OWNER_NONE);

`ifdef DMEM_ARB_ADDR_CHECK_EN
    localparam logic [REG_WIDTH:0] c_DEPTH = (REG_WIDTH + 1)'(DMEM_DEPTH);

    logic r_rd_oor_q;
    logic r_addr_err_q;

    // Extra bit on the address so a depth of 2**REG_WIDTH still compares
    assign w_addr_oor = w_win & ({1'b0, w_win_addr} >= c_DEPTH);

    // Remember whether the outstanding read was out of range; flag is sticky
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_oor_q   <= 1'b0;
            r_addr_err_q <= 1'b0;
        end else begin
            r_rd_oor_q   <= w_addr_oor & ~w_win_wr_en;
            r_addr_err_q <= r_addr_err_q | w_addr_oor;
        end
    end

    assign addr_err    = r_addr_err_q;
    assign w_rd_return = r_rd_oor_q ? '0 : dmem_rd_data;
`else
    assign w_addr_oor  = 1'b0;
    assign w_rd_return = dmem_rd_data;
`endif

    // Next DMEM command: write strobe only on a granted in-range write
    always_comb begin
        w_dmem_wr_en_d   = w_win & w_win_wr_en & ~w_addr_oor;
        w_dmem_addr_d    = w_win_addr;
        w_dmem_wr_data_d = w_win_wr_data;
        w_rd_pending_d   = w_win & ~w_win_wr_en;
    end

    // Command, owner and read-pending registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_owner_q        <= OWNER_NONE;
            r_rd_pending_q   <= 1'b0;
            r_dmem_wr_en_q   <= 1'b0;
            r_dmem_addr_q    <= '0;
            r_dmem_wr_data_q <= '0;
        end else begin
            r_owner_q        <= w_owner_d;
            r_rd_pending_q   <= w_rd_pending_d;
            r_dmem_wr_en_q   <= w_dmem_wr_en_d;
            r_dmem_addr_q    <= w_dmem_addr_d;
            r_dmem_wr_data_q <= w_dmem_wr_data_d;
        end
    end

    assign dmem_wr_en   = r_dmem_wr_en_q;
    assign dmem_addr    = r_dmem_addr_q;
    assign dmem_wr_data = r_dmem_wr_data_q;

    // Steer the returning read data to last cycle's owner; the other port sees zero
    always_comb begin
        cpu_rd_valid = 1'b0;
        cpu_rd_data  = '0;
        dma_rd_valid = 1'b0;
        dma_rd_data  = '0;
        if (r_rd_pending_q) begin
            if (r_owner_q == OWNER_CPU) begin
                cpu_rd_valid = 1'b1;
                cpu_rd_data  = w_rd_return;
            end else if (r_owner_q == OWNER_DMA) begin
                dma_rd_valid = 1'b1;
                dma_rd_data  = w_rd_return;
            end
        end
    end

endmodule : dmem_arbiter
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_dmem_arbiter
// Description : Self-checking bench for dmem_arbiter with a behavioural DMEM
//               and a golden memory/arbitration model. Build with
//               DMEM_ARB_ADDR_CHECK_EN to cover the address-check option.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

    localparam int W     = 32;
    localparam int DEPTH = 256;
    localparam int LIMIT = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         cpu_req, cpu_wr_en, cpu_stall, cpu_rd_valid;
    logic [W-1:0] cpu_addr, cpu_wr_data, cpu_rd_data;
    logic         dma_req, dma_wr_en, dma_gnt, dma_rd_valid;
    logic [W-1:0] dma_addr, dma_wr_data, dma_rd_data;
    logic         dmem_wr_en;
    logic [W-1:0] dmem_addr, dmem_wr_data, dmem_rd_data;
`ifdef DMEM_ARB_ADDR_CHECK_EN
    logic         addr_err;
`endif

    logic [W-1:0] dmem [0:DEPTH-1];
    logic [W-1:0] gold [0:DEPTH-1];
    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(
        .REG_WIDTH    (W),
        .DMEM_DEPTH   (DEPTH),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .cpu_req      (cpu_req),
        .cpu_wr_en    (cpu_wr_en),
        .cpu_addr     (cpu_addr),
        .cpu_wr_data  (cpu_wr_data),
        .cpu_stall    (cpu_stall),
        .cpu_rd_valid (cpu_rd_valid),
        .cpu_rd_data  (cpu_rd_data),
        .dma_req      (dma_req),
        .dma_wr_en    (dma_wr_en),
        .dma_addr     (dma_addr),
        .dma_wr_data  (dma_wr_data),
        .dma_gnt      (dma_gnt),
        .dma_rd_valid (dma_rd_valid),
        .dma_rd_data  (dma_rd_data),
        .dmem_wr_en   (dmem_wr_en),
        .dmem_addr    (dmem_addr),
        .dmem_wr_data (dmem_wr_data),
`ifdef DMEM_ARB_ADDR_CHECK_EN
        .addr_err     (addr_err),
`endif
        .dmem_rd_data (dmem_rd_data)
    );

    // Behavioural DMEM: combinational read, write at the clock edge, wraps on 8 bits
    assign dmem_rd_data = dmem[dmem_addr[7:0]];
    always @(posedge clk) begin
        if (dmem_wr_en) dmem[dmem_addr[7:0]] <= dmem_wr_data;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cpu_req = 1'b0; cpu_wr_en = 1'b0; cpu_addr = '0; cpu_wr_data = '0;
        dma_req = 1'b0; dma_wr_en = 1'b0; dma_addr = '0; dma_wr_data = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle();
        cpu_req = 1'b1; cpu_wr_en = 1'b1; cpu_addr = 32'd9; cpu_wr_data = 32'h0BAD_F00D;
        step(); step();
        n_tests++; if (dmem_wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en: got %0h want 0", dmem_wr_en); end
        n_tests++; if (dmem_addr !== '0) begin n_fail++; $display("FAIL reset_addr: got %0h want 0", dmem_addr); end
        n_tests++; if (dmem_wr_data !== '0) begin n_fail++; $display("FAIL reset_wdata: got %0h want 0", dmem_wr_data); end
        n_tests++; if (cpu_rd_valid !== 1'b0 || dma_rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got cpu %0b dma %0b want 0 0", cpu_rd_valid, dma_rd_valid); end
        n_tests++; if (cpu_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %0b want 0", cpu_stall); end
`ifdef DMEM_ARB_ADDR_CHECK_EN
        n_tests++; if (addr_err !== 1'b0) begin n_fail++; $display("FAIL reset_addr_err: got %0b want 0", addr_err); end
`endif
        reset = 1'b0;
        step();
        n_tests++; if (dmem_wr_en !== 1'b1 || dmem_addr !== 32'd9 || dmem_wr_data !== 32'h0BAD_F00D) begin
            n_fail++; $display("FAIL release_grant: got we %0b addr %0h data %0h want 1 9 0badf00d", dmem_wr_en, dmem_addr, dmem_wr_data);
        end
        gold[9] = 32'h0BAD_F00D;
        idle();
        step();
    endtask

    // Give every DMEM word a known random value through the CPU port
    task automatic init_memory();
        for (int i = 0; i < DEPTH; i++) begin
            cpu_req = 1'b1; cpu_wr_en = 1'b1; cpu_addr = i; cpu_wr_data = $urandom();
            gold[i] = cpu_wr_data;
            step();
        end
        idle();
        step();
    endtask

    task automatic test_cpu_only();
        cpu_req = 1'b1; cpu_wr_en = 1'b1; cpu_addr = 32'd5; cpu_wr_data = 32'hDEAD_BEEF;
        #1;
        n_tests++; if (cpu_stall !== 1'b0) begin n_fail++; $display("FAIL cpu_wr_stall: got %0b want 0", cpu_stall); end
        step();
        gold[5] = 32'hDEAD_BEEF;
        n_tests++; if (dmem_wr_en !== 1'b1 || dmem_addr !== 32'd5 || dmem_wr_data !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL cpu_wr_cmd: got we %0b addr %0h data %0h want 1 5 deadbeef", dmem_wr_en, dmem_addr, dmem_wr_data);
        end
        cpu_wr_en = 1'b0; cpu_wr_data = '0;
        #1;
        n_tests++; if (cpu_stall !== 1'b0) begin n_fail++; $display("FAIL cpu_rd_stall: got %0b want 0", cpu_stall); end
        step();
        n_tests++; if (cpu_rd_valid !== 1'b1 || cpu_rd_data !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL cpu_rd_return: got v %0b d %0h want 1 deadbeef", cpu_rd_valid, cpu_rd_data);
        end
        n_tests++; if (dmem_wr_en !== 1'b0 || dma_rd_valid !== 1'b0) begin
            n_fail++; $display("FAIL cpu_rd_side: got we %0b dma_v %0b want 0 0", dmem_wr_en, dma_rd_valid);
        end
        idle();
        step();
        n_tests++; if (cpu_rd_valid !== 1'b0) begin n_fail++; $display("FAIL cpu_rd_once: got %0b want 0", cpu_rd_valid); end
    endtask

    task automatic test_dma_only();
        dma_req = 1'b1; dma_wr_en = 1'b1; dma_addr = 32'd7; dma_wr_data = 32'h0000_1234;
        #1;
        n_tests++; if (dma_gnt !== 1'b1) begin n_fail++; $display("FAIL dma_wr_gnt: got %0b want 1", dma_gnt); end
        step();
        gold[7] = 32'h0000_1234;
        n_tests++; if (dmem_wr_en !== 1'b1 || dmem_addr !== 32'd7) begin
            n_fail++; $display("FAIL dma_wr_cmd: got we %0b addr %0h want 1 7", dmem_wr_en, dmem_addr);
        end
        dma_wr_en = 1'b0; dma_wr_data = '0;
        #1;
        n_tests++; if (dma_gnt !== 1'b1) begin n_fail++; $display("FAIL dma_rd_gnt: got %0b want 1", dma_gnt); end
        step();
        n_tests++; if (dma_rd_valid !== 1'b1 || dma_rd_data !== 32'h0000_1234) begin
            n_fail++; $display("FAIL dma_rd_return: got v %0b d %0h want 1 1234", dma_rd_valid, dma_rd_data);
        end
        n_tests++; if (cpu_rd_valid !== 1'b0 || cpu_rd_data !== '0) begin
            n_fail++; $display("FAIL dma_rd_cpu_side: got v %0b d %0h want 0 0", cpu_rd_valid, cpu_rd_data);
        end
        idle();
        step();
        n_tests++; if (dma_rd_valid !== 1'b0) begin n_fail++; $display("FAIL dma_rd_once: got %0b want 0", dma_rd_valid); end
    endtask

    // Both ports read continuously: DMA must get every fifth slot
    task automatic test_contention();
        int  cpu_k = 0;
        int  dma_j = 0;
        int  seen_dma_gnt = 0;
        int  seen_cpu_v = 0;
        bit  exp_force;
        for (int c = 0; c < 15; c++) begin
            cpu_req = 1'b1; cpu_wr_en = 1'b0; cpu_addr = 10 + cpu_k;
            dma_req = 1'b1; dma_wr_en = 1'b0; dma_addr = 100 + dma_j;
            #1;
            exp_force = ((c % 5) == 4);
            n_tests++; if (dma_gnt !== exp_force || cpu_stall !== exp_force) begin
                n_fail++; $display("FAIL contend_gnt c%0d: got gnt %0b stall %0b want %0b %0b", c, dma_gnt, cpu_stall, exp_force, exp_force);
            end
            if (dma_gnt === 1'b1) seen_dma_gnt++;
            step();
            if (cpu_rd_valid === 1'b1) seen_cpu_v++;
            n_tests++; if (cpu_rd_valid !== !exp_force || dma_rd_valid !== exp_force) begin
                n_fail++; $display("FAIL contend_valid c%0d: got cpu %0b dma %0b want %0b %0b", c, cpu_rd_valid, dma_rd_valid, !exp_force, exp_force);
            end
            if (exp_force) begin
                n_tests++; if (dma_rd_data !== gold[100 + dma_j]) begin
                    n_fail++; $display("FAIL contend_dma_data c%0d: got %0h want %0h", c, dma_rd_data, gold[100 + dma_j]);
                end
                dma_j++;
            end else begin
                n_tests++; if (cpu_rd_data !== gold[10 + cpu_k]) begin
                    n_fail++; $display("FAIL contend_cpu_data c%0d: got %0h want %0h", c, cpu_rd_data, gold[10 + cpu_k]);
                end
                cpu_k++;
            end
        end
        n_tests++; if (seen_dma_gnt != 3 || seen_cpu_v != 12) begin
            n_fail++; $display("FAIL contend_totals: got dma %0d cpu %0d want 3 12", seen_dma_gnt, seen_cpu_v);
        end
        idle();
        step();
    endtask

    task automatic test_mid_read_reset();
        // Reset sampled at the same edge that would complete the CPU read grant
        cpu_req = 1'b1; cpu_wr_en = 1'b0; cpu_addr = 32'd5; reset = 1'b1;
        #1;
        n_tests++; if (cpu_stall !== 1'b0) begin n_fail++; $display("FAIL midrst_stall: got %0b want 0", cpu_stall); end
        step();
        n_tests++; if (cpu_rd_valid !== 1'b0 || dmem_addr !== '0 || dmem_wr_en !== 1'b0) begin
            n_fail++; $display("FAIL midrst_drop: got v %0b addr %0h we %0b want 0 0 0", cpu_rd_valid, dmem_addr, dmem_wr_en);
        end
        reset = 1'b0; idle();
        step();
        n_tests++; if (cpu_rd_valid !== 1'b0 || dma_rd_valid !== 1'b0) begin
            n_fail++; $display("FAIL midrst_idle: got cpu %0b dma %0b want 0 0", cpu_rd_valid, dma_rd_valid);
        end
        // Read granted, reset raised during its return cycle: valid ends at the reset edge
        cpu_req = 1'b1; cpu_wr_en = 1'b0; cpu_addr = 32'd5;
        step();
        n_tests++; if (cpu_rd_valid !== 1'b1 || cpu_rd_data !== gold[5]) begin
            n_fail++; $display("FAIL midrst_before: got v %0b d %0h want 1 %0h", cpu_rd_valid, cpu_rd_data, gold[5]);
        end
        idle(); reset = 1'b1;
        step();
        n_tests++; if (cpu_rd_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_after: got %0b want 0", cpu_rd_valid); end
        reset = 1'b0;
        step();
    endtask

    // Random traffic against a transaction-level model of the arbiter
    task automatic test_random();
        int           refused = 0;
        bit           c_hold = 0, d_hold = 0;
        bit           c_req = 0, c_wr = 0, d_req = 0, d_wr = 0;
        logic [W-1:0] c_addr = '0, c_wd = '0, d_addr = '0, d_wd = '0;
        bit           force_dma, cw, dw;
        bit           e_cv = 0, e_dv = 0, e_wr = 0;
        logic [W-1:0] e_cd = '0, e_dd = '0, e_addr = '0, e_wd = '0;
        reset = 1'b1; idle();
        step();
        reset = 1'b0;
        for (int i = 0; i < 400; i++) begin
            n_tests++; if (cpu_rd_valid !== e_cv || cpu_rd_data !== e_cd) begin
                n_fail++; $display("FAIL rand_cpu_rd i%0d: got v %0b d %0h want %0b %0h", i, cpu_rd_valid, cpu_rd_data, e_cv, e_cd);
            end
            n_tests++; if (dma_rd_valid !== e_dv || dma_rd_data !== e_dd) begin
                n_fail++; $display("FAIL rand_dma_rd i%0d: got v %0b d %0h want %0b %0h", i, dma_rd_valid, dma_rd_data, e_dv, e_dd);
            end
            n_tests++; if (dmem_wr_en !== e_wr || dmem_addr !== e_addr || dmem_wr_data !== e_wd) begin
                n_fail++; $display("FAIL rand_cmd i%0d: got we %0b a %0h d %0h want %0b %0h %0h", i, dmem_wr_en, dmem_addr, dmem_wr_data, e_wr, e_addr, e_wd);
            end
            if (!c_hold) begin
                c_req = ($urandom_range(0, 99) < 70); c_wr = $urandom_range(0, 1);
                c_addr = $urandom_range(0, DEPTH - 1); c_wd = $urandom();
            end
            if (!d_hold) begin
                d_req = ($urandom_range(0, 99) < 50); d_wr = $urandom_range(0, 1);
                d_addr = $urandom_range(0, DEPTH - 1); d_wd = $urandom();
            end
            cpu_req = c_req; cpu_wr_en = c_wr; cpu_addr = c_addr; cpu_wr_data = c_wd;
            dma_req = d_req; dma_wr_en = d_wr; dma_addr = d_addr; dma_wr_data = d_wd;
            #1;
            force_dma = (refused >= LIMIT);
            cw = c_req && !force_dma;
            dw = d_req && (!c_req || force_dma);
            n_tests++; if (dma_gnt !== dw || cpu_stall !== (c_req && !cw)) begin
                n_fail++; $display("FAIL rand_arb i%0d: got gnt %0b stall %0b want %0b %0b", i, dma_gnt, cpu_stall, dw, c_req && !cw);
            end
            if (d_req && !dw) refused = (refused < LIMIT) ? refused + 1 : refused;
            else refused = 0;
            c_hold = c_req && !cw;
            d_hold = d_req && !dw;
            e_cv = 0; e_dv = 0; e_cd = '0; e_dd = '0; e_wr = 0;
            if (cw) begin
                e_addr = c_addr; e_wd = c_wd;
                if (c_wr) begin e_wr = 1; gold[c_addr[7:0]] = c_wd; end
                else begin e_cv = 1; e_cd = gold[c_addr[7:0]]; end
            end else if (dw) begin
                e_addr = d_addr; e_wd = d_wd;
                if (d_wr) begin e_wr = 1; gold[d_addr[7:0]] = d_wd; end
                else begin e_dv = 1; e_dd = gold[d_addr[7:0]]; end
            end
            step();
        end
        idle();
        step();
    endtask

`ifdef DMEM_ARB_ADDR_CHECK_EN
    task automatic test_addr_check();
        cpu_req = 1'b1; cpu_wr_en = 1'b1; cpu_addr = 32'd256; cpu_wr_data = 32'hFFFF_0000;
        step();
        n_tests++; if (dmem_wr_en !== 1'b0 || addr_err !== 1'b1) begin
            n_fail++; $display("FAIL oor_write: got we %0b err %0b want 0 1", dmem_wr_en, addr_err);
        end
        idle();
        for (int i = 0; i < 10; i++) step();
        n_tests++; if (addr_err !== 1'b1) begin n_fail++; $display("FAIL oor_sticky: got %0b want 1", addr_err); end
        cpu_req = 1'b1; cpu_wr_en = 1'b1; cpu_addr = 32'd3; cpu_wr_data = 32'h3333_AAAA;
        step();
        gold[3] = 32'h3333_AAAA;
        n_tests++; if (dmem_wr_en !== 1'b1 || dmem_addr !== 32'd3) begin
            n_fail++; $display("FAIL oor_next_write: got we %0b addr %0h want 1 3", dmem_wr_en, dmem_addr);
        end
        cpu_wr_en = 1'b0; cpu_addr = 32'd300;
        step();
        n_tests++; if (cpu_rd_valid !== 1'b1 || cpu_rd_data !== '0) begin
            n_fail++; $display("FAIL oor_read: got v %0b d %0h want 1 0", cpu_rd_valid, cpu_rd_data);
        end
        cpu_addr = 32'd3;
        step();
        n_tests++; if (cpu_rd_valid !== 1'b1 || cpu_rd_data !== 32'h3333_AAAA) begin
            n_fail++; $display("FAIL oor_inrange_read: got v %0b d %0h want 1 3333aaaa", cpu_rd_valid, cpu_rd_data);
        end
        idle();
        step();
    endtask
`endif

    initial begin
        reset = 1'b1;
        idle();
        test_reset();
        init_memory();
        test_cpu_only();
        test_dma_only();
        test_contention();
        test_mid_read_reset();
        test_random();
`ifdef DMEM_ARB_ADDR_CHECK_EN
        test_addr_check();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule : tb_dmem_arbiter
`default_nettype wire
